// File: rtl/adder_pkg.sv
// Shared types and constants for the serial slice-adder sequencer.
package adder_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SLICE = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of slices needed to cover width bits; the last slice may be partial.
  function automatic int unsigned nslice(input int unsigned width, input int unsigned slice);
    return (width + slice - 1) / slice;
  endfunction

endpackage

// File: rtl/adder_slice_seq_if.sv
// Operand request / result handshake bundle for adder_slice_seq.
interface adder_slice_seq_if
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );

endinterface

// File: rtl/adder_slice.sv
// Combinational SLICE-bit adder partition; exact reference, replaceable by an approximated netlist.
module adder_slice #(
  parameter int unsigned SLICE = 5
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = (SLICE+1)'(a) + (SLICE+1)'(b) + (SLICE+1)'(cin);

endmodule

// File: rtl/adder_slice_seq.sv
// Serial adder: feeds one SLICE-bit slice per cycle through adder_slice, carry registered between slices.
module adder_slice_seq
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SLICE = DEF_SLICE
) (
  input logic               clk,
  input logic               rst,
  adder_slice_seq_if.slave  bus
);

  localparam int unsigned NSLICE = nslice(WIDTH, SLICE);
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned PAD_W  = NSLICE * SLICE;
  localparam int unsigned BASE_W = (PAD_W > 1) ? $clog2(PAD_W) : 1;
  localparam int unsigned LAST_W = WIDTH - (NSLICE - 1) * SLICE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t           state_q, state_d;
  logic             in_ready_q, out_valid_q, busy_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q, ovf_q;
  logic [IDX_W-1:0] idx_q;

  logic              accept_c, release_c, last_c;
  logic [BASE_W-1:0] base_c;
  logic [SLICE-1:0]  slice_a_c, slice_b_c, slice_sum_c;
  logic              slice_cout_c, final_cout_c, final_ovf_c;
  logic [WIDTH-1:0]  sum_d_c, slice_mask_c;

  assign accept_c  = bus.in_valid & in_ready_q;
  assign release_c = out_valid_q & bus.out_ready;
  assign last_c    = (state_q == RUN) && (idx_q == LAST_IDX);

  // FSM state and registered handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c)  state_d = RUN;
      RUN:     if (last_c)    state_d = DONE;
      DONE:    if (release_c) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Slice mux: right shift zero-fills, so a partial last slice sees zeros above WIDTH-1.
  assign base_c    = BASE_W'(32'(idx_q) * SLICE);
  assign slice_a_c = SLICE'(a_q >> base_c);
  assign slice_b_c = SLICE'(b_q >> base_c);

  adder_slice #(.SLICE(SLICE)) u_slice (
    .a    (slice_a_c),
    .b    (slice_b_c),
    .cin  (carry_q),
    .sum  (slice_sum_c),
    .cout (slice_cout_c)
  );

  // Slice demux into the sum register; bits beyond WIDTH fall off the shift.
  assign slice_mask_c = WIDTH'({SLICE{1'b1}}) << base_c;
  assign sum_d_c      = (sum_q & ~slice_mask_c) | (WIDTH'(slice_sum_c) << base_c);

  // Final carry is the carry out of bit WIDTH-1, not of the slice's top bit.
  if (LAST_W == SLICE) begin : g_full_last
    assign final_cout_c = slice_cout_c;
  end else begin : g_partial_last
    assign final_cout_c = slice_sum_c[LAST_W];
  end

  assign final_ovf_c = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                       (slice_sum_c[LAST_W-1] != a_q[WIDTH-1]);

  // Operand, carry, index and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            carry_q <= bus.in_cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q   <= sum_d_c;
          carry_q <= slice_cout_c;
          if (last_c) begin
            idx_q  <= '0;
            cout_q <= final_cout_c;
            ovf_q  <= final_ovf_c;
          end else begin
            idx_q  <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_slice_seq.sv
// Self-checking bench for adder_slice_seq in three geometries: 32/5, 5/5 and 13/4.
module tb_adder_slice_seq;
  import adder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  int          sel;
  logic        drv_in_valid, drv_cin, drv_out_ready;
  logic [31:0] drv_a, drv_b;

  logic        obs_in_ready, obs_out_valid, obs_busy, obs_cout, obs_ovf;
  logic [31:0] obs_sum;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  adder_slice_seq_if #(.WIDTH(32)) bus32 ();
  adder_slice_seq_if #(.WIDTH(5))  bus5  ();
  adder_slice_seq_if #(.WIDTH(13)) bus13 ();

  adder_slice_seq #(.WIDTH(32), .SLICE(5)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
  adder_slice_seq #(.WIDTH(5),  .SLICE(5)) u_dut5  (.clk(clk), .rst(rst), .bus(bus5));
  adder_slice_seq #(.WIDTH(13), .SLICE(4)) u_dut13 (.clk(clk), .rst(rst), .bus(bus13));

  // Only the selected instance sees handshakes; the others stay idle.
  assign bus32.in_valid  = (sel == 0) && drv_in_valid;
  assign bus5.in_valid   = (sel == 1) && drv_in_valid;
  assign bus13.in_valid  = (sel == 2) && drv_in_valid;
  assign bus32.out_ready = (sel == 0) && drv_out_ready;
  assign bus5.out_ready  = (sel == 1) && drv_out_ready;
  assign bus13.out_ready = (sel == 2) && drv_out_ready;
  assign bus32.in_a = drv_a;
  assign bus32.in_b = drv_b;
  assign bus5.in_a  = drv_a[4:0];
  assign bus5.in_b  = drv_b[4:0];
  assign bus13.in_a = drv_a[12:0];
  assign bus13.in_b = drv_b[12:0];
  assign bus32.in_cin = drv_cin;
  assign bus5.in_cin  = drv_cin;
  assign bus13.in_cin = drv_cin;

  always_comb begin
    obs_in_ready  = bus32.in_ready;
    obs_out_valid = bus32.out_valid;
    obs_busy      = bus32.busy;
    obs_cout      = bus32.out_cout;
    obs_ovf       = bus32.out_ovf;
    obs_sum       = bus32.out_sum;
    if (sel == 1) begin
      obs_in_ready  = bus5.in_ready;
      obs_out_valid = bus5.out_valid;
      obs_busy      = bus5.busy;
      obs_cout      = bus5.out_cout;
      obs_ovf       = bus5.out_ovf;
      obs_sum       = 32'(bus5.out_sum);
    end else if (sel == 2) begin
      obs_in_ready  = bus13.in_ready;
      obs_out_valid = bus13.out_valid;
      obs_busy      = bus13.busy;
      obs_cout      = bus13.out_cout;
      obs_ovf       = bus13.out_ovf;
      obs_sum       = 32'(bus13.out_sum);
    end
  end

  function automatic int width_of(input int s);
    return (s == 1) ? 5 : (s == 2) ? 13 : 32;
  endfunction

  function automatic int slice_of(input int s);
    return (s == 1) ? 5 : (s == 2) ? 4 : 5;
  endfunction

  // Reference: plain integer addition on the low w bits; returns {ovf, cout, sum}.
  function automatic logic [33:0] ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin);
    logic [32:0] mask, am, bm, full;
    logic        ovf;
    mask = (33'd1 << w) - 33'd1;
    am   = {1'b0, a} & mask;
    bm   = {1'b0, b} & mask;
    full = am + bm + 33'(cin);
    ovf  = (a[w-1] == b[w-1]) && (full[w-1] != a[w-1]);
    return {ovf, full[w], full[31:0] & mask[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [33:0] exp);
    check(tag, 64'({obs_ovf, obs_cout, obs_sum}), 64'(exp));
  endtask

  // One full transaction on the selected instance, with junk inputs while busy.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input int in_gap, input int out_gap);
    int          w, ns, lat;
    bit          done;
    logic [33:0] exp;
    w   = width_of(sel);
    ns  = (w + slice_of(sel) - 1) / slice_of(sel);
    exp = ref_add(w, a, b, cin);
    repeat (in_gap) @(negedge clk);
    @(negedge clk);
    drv_in_valid  = 1'b1;
    drv_a         = a;
    drv_b         = b;
    drv_cin       = cin;
    drv_out_ready = 1'b0;
    check("ready_before_accept", 64'(obs_in_ready), 64'd1);
    @(posedge clk);
    lat  = 0;
    done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (obs_out_valid) begin
        done = 1'b1;
      end else begin
        check("run_flags", 64'({obs_in_ready, obs_busy}), 64'(2'b01));
        drv_in_valid  = 1'($urandom_range(0, 1));
        drv_a         = $urandom;
        drv_b         = $urandom;
        drv_cin       = 1'($urandom_range(0, 1));
        drv_out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        lat++;
      end
    end
    check("latency", 64'(lat), 64'(ns));
    drv_out_ready = 1'b0;
    for (int g = 0; g < out_gap; g++) begin
      drv_in_valid = 1'b1;
      drv_a        = $urandom;
      drv_b        = $urandom;
      check_result("hold_result", exp);
      check("hold_flags", 64'({obs_in_ready, obs_out_valid, obs_busy}), 64'(3'b011));
      @(posedge clk);
      @(negedge clk);
    end
    check_result("result", exp);
    check("done_flags", 64'({obs_in_ready, obs_out_valid, obs_busy}), 64'(3'b011));
    drv_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_out_ready = 1'b0;
    drv_in_valid  = 1'b0;
    check("idle_after_release", 64'({obs_in_ready, obs_out_valid, obs_busy}), 64'(3'b100));
  endtask

  initial begin
    rst           = 1'b1;
    sel           = 0;
    drv_in_valid  = 1'b0;
    drv_out_ready = 1'b0;
    drv_cin       = 1'b0;
    drv_a         = '0;
    drv_b         = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state of every instance
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("reset_flags", 64'({obs_in_ready, obs_out_valid, obs_busy}), 64'(3'b100));
      check_result("reset_result", 34'd0);
    end
    sel = 0;

    // Directed corner cases, 32/5
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0, 0);
    run_op(32'hC000_0000, 32'h4000_0000, 1'b1, 0, 0);
    run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 0, 0);
    run_op(32'h1234_5678, 32'h8765_4321, 1'b1, 1, 5);
    run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 0, 0);

    // Reset mid-RUN aborts the operation
    @(negedge clk);
    drv_in_valid = 1'b1;
    drv_a        = 32'hDEAD_BEEF;
    drv_b        = 32'h0101_0101;
    @(posedge clk);
    @(negedge clk);
    drv_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_flags", 64'({obs_in_ready, obs_out_valid, obs_busy}), 64'(3'b100));
    check_result("abort_result", 34'd0);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("abort_no_valid", 64'(obs_out_valid), 64'd0);
    end
    run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 0, 0);

    // Random traffic, 32/5
    for (int k = 0; k < 2500; k++) begin
      logic [31:0] a, b;
      a = (k % 9 == 0) ? 32'hFFFF_FFFF : $urandom;
      b = (k % 11 == 0) ? 32'h8000_0000 : $urandom;
      run_op(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // 5/5: single slice, latency 1
    sel = 1;
    run_op(32'h0000_001F, 32'h0000_0001, 1'b0, 0, 0);
    run_op(32'h0000_000F, 32'h0000_0001, 1'b0, 0, 3);
    run_op(32'h0000_0010, 32'h0000_0010, 1'b1, 0, 0);
    for (int k = 0; k < 1500; k++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // 13/4: partial last slice of one bit
    sel = 2;
    run_op(32'h0000_1FFF, 32'h0000_0001, 1'b0, 0, 0);
    run_op(32'h0000_0FFF, 32'h0000_0001, 1'b0, 0, 0);
    run_op(32'h0000_1000, 32'h0000_1000, 1'b1, 0, 2);
    for (int k = 0; k < 1500; k++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
